// File: rtl/lcd_reader.sv
// lcd_reader: HD44780 4-bit read cycle engine with optional busy-flag polling
module lcd_reader #(
  parameter int FREQ       = 50000000,
  parameter int POLL_LIMIT = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       readReq,
  input  logic       readRs,
  input  logic       pollMode,
  input  logic [3:0] LCD_D_IN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       LCD_D_OE,
  output logic       ready,
  output logic [7:0] dataOut,
  output logic       busyFlag,
  output logic       readDone,
  output logic       timeout
);
  localparam logic [20:0] PHASE_LAST = 21'(FREQ / 1000000 - 1);
  localparam logic [16:0] LIMIT = 17'(POLL_LIMIT);
  typedef enum logic [2:0] {IDLE, SETUP, E_HI1, E_LO1, E_HI2, E_LO2, TURN} state_t;
  state_t state;
  logic [20:0] phaseCnt;
  logic [15:0] pollCnt;
  logic [16:0] pollNext;
  logic [3:0] hiNib, loNib;
  logic rsLatched, polling, phaseEnd;
  assign phaseEnd = phaseCnt == '0;
  assign pollNext = {1'b0, pollCnt} + 17'd1;
  // Phase sequencer: every non-idle phase lasts N cycles; all bus outputs are registered on phase transitions
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      phaseCnt <= '0;
      pollCnt <= '0;
      rsLatched <= 1'b0;
      polling <= 1'b0;
      hiNib <= '0;
      loNib <= '0;
      LCD_RS <= 1'b0;
      LCD_RW <= 1'b0;
      LCD_E <= 1'b0;
      LCD_D_OE <= 1'b1;
      ready <= 1'b1;
      dataOut <= '0;
      busyFlag <= 1'b0;
      readDone <= 1'b0;
      timeout <= 1'b0;
    end else begin
      readDone <= 1'b0;
      timeout <= 1'b0;
      if (state != IDLE) phaseCnt <= phaseEnd ? PHASE_LAST : phaseCnt - 21'd1;
      case (state)
        IDLE: if (readReq) begin
          rsLatched <= readRs;
          polling <= pollMode & ~readRs;
          pollCnt <= '0;
          phaseCnt <= PHASE_LAST;
          LCD_RS <= readRs;
          LCD_RW <= 1'b1;
          LCD_D_OE <= 1'b0;
          ready <= 1'b0;
          state <= SETUP;
        end
        SETUP: if (phaseEnd) begin
          LCD_E <= 1'b1;
          state <= E_HI1;
        end
        E_HI1: if (phaseEnd) begin
          hiNib <= LCD_D_IN;
          LCD_E <= 1'b0;
          state <= E_LO1;
        end
        E_LO1: if (phaseEnd) begin
          LCD_E <= 1'b1;
          state <= E_HI2;
        end
        E_HI2: if (phaseEnd) begin
          loNib <= LCD_D_IN;
          LCD_E <= 1'b0;
          state <= E_LO2;
        end
        E_LO2: if (phaseEnd) begin
          pollCnt <= pollNext[15:0];
          if (polling && hiNib[3] && pollNext < LIMIT) state <= SETUP;
          else begin
            LCD_RW <= 1'b0;
            state <= TURN;
          end
        end
        TURN: if (phaseEnd) begin
          dataOut <= {hiNib, loNib};
          busyFlag <= ~rsLatched & hiNib[3];
          readDone <= 1'b1;
          timeout <= polling & hiNib[3];
          LCD_D_OE <= 1'b1;
          LCD_RS <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
